// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - VGA 640x480 timing defaults and sync-receiver state encoding
package vga_timing_pkg;

  localparam int H_TOTAL_DEF      = 800;
  localparam int H_ACTIVE_DEF     = 640;
  localparam int H_SYNC_START_DEF = 656;
  localparam int V_TOTAL_DEF      = 525;
  localparam int V_ACTIVE_DEF     = 480;
  localparam int V_SYNC_START_DEF = 490;
  localparam int LOCK_LINES_DEF   = 4;

  // Samples without an hsync fall before the receiver abandons alignment.
  localparam int          PER_TIMEOUT = 1024;
  localparam logic [11:0] PER_MAX     = 12'hFFF;

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_H_ALIGN = 2'd1,
    ST_V_ALIGN = 2'd2,
    ST_LOCKED  = 2'd3
  } vga_state_t;

  function automatic logic [9:0] wrap_inc(input logic [9:0] v, input int total);
    return (v == 10'(total - 1)) ? 10'd0 : v + 10'd1;
  endfunction

endpackage

// File: rtl/vga_edge_det.sv
// rtl/vga_edge_det.sv - falling-edge detector on a sampled sync line, advanced only on i_ce
module vga_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic i_ce,
  input  logic i_sig,
  output logic o_fall
);

  logic r_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev <= 1'b1;
    end else if (i_ce) begin
      r_prev <= i_sig;
    end
  end

  assign o_fall = i_ce && r_prev && !i_sig;

endmodule

// File: rtl/vga_sync_rx.sv
// rtl/vga_sync_rx.sv - VGA sync receiver: locks hcnt/vcnt to incoming syncs and tags captured pixels
module vga_sync_rx
  import vga_timing_pkg::*;
#(
  parameter int H_TOTAL      = H_TOTAL_DEF,
  parameter int H_ACTIVE     = H_ACTIVE_DEF,
  parameter int H_SYNC_START = H_SYNC_START_DEF,
  parameter int V_TOTAL      = V_TOTAL_DEF,
  parameter int V_ACTIVE     = V_ACTIVE_DEF,
  parameter int V_SYNC_START = V_SYNC_START_DEF,
  parameter int LOCK_LINES   = LOCK_LINES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_ce,
  input  logic        vga_hs,
  input  logic        vga_vs,
  input  logic [11:0] vga_i,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [11:0] pix_data,
  output logic        frame_start,
  output logic        locked,
  output logic        lock_lost,
  output logic [11:0] line_len
);

  logic        w_hs_fall, w_vs_fall;
  logic [9:0]  w_hpos, w_vpos;
  logic        w_hwrap, w_per_ok, w_vlen_ok, w_timeout, w_pix_valid;

  logic [9:0]  r_hcnt, r_vcnt;
  logic [11:0] r_per, r_lines, r_line_len;
  logic [7:0]  r_good;
  logic        r_vseen;
  vga_state_t  r_state;

  logic        r_pix_valid, r_frame_start, r_locked, r_lock_lost;
  logic [9:0]  r_pix_x, r_pix_y;
  logic [11:0] r_pix_data;

  vga_edge_det u_hs_det (
    .clk    (clk),
    .rst    (rst),
    .i_ce   (pix_ce),
    .i_sig  (vga_hs),
    .o_fall (w_hs_fall)
  );

  vga_edge_det u_vs_det (
    .clk    (clk),
    .rst    (rst),
    .i_ce   (pix_ce),
    .i_sig  (vga_vs),
    .o_fall (w_vs_fall)
  );

  // Position of the current sample: a sync fall pins it to the sync start.
  assign w_hpos      = w_hs_fall ? 10'(H_SYNC_START) : r_hcnt;
  assign w_vpos      = w_vs_fall ? 10'(V_SYNC_START) : r_vcnt;
  assign w_hwrap     = (w_hpos == 10'(H_TOTAL - 1));
  assign w_per_ok    = (r_per == 12'(H_TOTAL));
  assign w_vlen_ok   = (r_lines == 12'(V_TOTAL));
  assign w_timeout   = pix_ce && !w_hs_fall && (r_per == 12'(PER_TIMEOUT - 1));
  assign w_pix_valid = pix_ce && (r_state == ST_LOCKED) &&
                       (w_hpos < 10'(H_ACTIVE)) && (w_vpos < 10'(V_ACTIVE));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hcnt     <= '0;
      r_vcnt     <= '0;
      r_per      <= '0;
      r_line_len <= '0;
    end else if (pix_ce) begin
      r_hcnt <= wrap_inc(w_hpos, H_TOTAL);
      r_vcnt <= w_hwrap ? wrap_inc(w_vpos, V_TOTAL) : w_vpos;
      if (w_hs_fall) begin
        r_line_len <= r_per;
        r_per      <= 12'd1;
      end else begin
        if (r_per != PER_MAX) r_per <= r_per + 12'd1;
        if (w_timeout) r_line_len <= 12'(PER_TIMEOUT);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_SEARCH;
      r_locked    <= 1'b0;
      r_lock_lost <= 1'b0;
      r_good      <= '0;
      r_lines     <= '0;
      r_vseen     <= 1'b0;
    end else if (pix_ce) begin
      if (w_hs_fall && r_lines != PER_MAX) r_lines <= r_lines + 12'd1;
      case (r_state)
        ST_SEARCH: begin
          if (w_hs_fall) begin
            r_state <= ST_H_ALIGN;
            r_good  <= '0;
          end
        end
        ST_H_ALIGN: begin
          if (w_timeout || (w_hs_fall && !w_per_ok)) begin
            r_state <= ST_SEARCH;
          end else if (w_hs_fall) begin
            if (r_good + 8'd1 == 8'(LOCK_LINES)) begin
              r_state <= ST_V_ALIGN;
              r_vseen <= 1'b0;
            end else begin
              r_good <= r_good + 8'd1;
            end
          end
        end
        ST_V_ALIGN: begin
          if (w_timeout || (w_hs_fall && !w_per_ok)) begin
            r_state <= ST_SEARCH;
          end else if (w_vs_fall) begin
            // Line count restarts at every vsync fall; a mismatched frame just re-aligns.
            r_vseen <= 1'b1;
            r_lines <= {11'd0, w_hs_fall};
            if (r_vseen && w_vlen_ok) begin
              r_state  <= ST_LOCKED;
              r_locked <= 1'b1;
            end
          end
        end
        ST_LOCKED: begin
          if (w_timeout || (w_hs_fall && !w_per_ok) || (w_vs_fall && !w_vlen_ok)) begin
            r_state     <= ST_SEARCH;
            r_locked    <= 1'b0;
            r_lock_lost <= 1'b1;
          end else if (w_vs_fall) begin
            r_lines <= {11'd0, w_hs_fall};
          end
        end
        default: begin
          r_state  <= ST_SEARCH;
          r_locked <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pix_valid   <= 1'b0;
      r_frame_start <= 1'b0;
      r_pix_x       <= '0;
      r_pix_y       <= '0;
      r_pix_data    <= '0;
    end else begin
      r_pix_valid   <= w_pix_valid;
      r_frame_start <= w_pix_valid && (w_hpos == 10'd0) && (w_vpos == 10'd0);
      if (pix_ce) begin
        r_pix_x    <= w_hpos;
        r_pix_y    <= w_vpos;
        r_pix_data <= vga_i;
      end
    end
  end

  assign pix_valid   = r_pix_valid;
  assign pix_x       = r_pix_x;
  assign pix_y       = r_pix_y;
  assign pix_data    = r_pix_data;
  assign frame_start = r_frame_start;
  assign locked      = r_locked;
  assign lock_lost   = r_lock_lost;
  assign line_len    = r_line_len;

endmodule

// File: tb/tb_vga_sync_rx.sv
// tb/tb_vga_sync_rx.sv - directed bench for vga_sync_rx on a reduced 20x10 timing
module tb_vga_sync_rx;

  localparam int HT  = 20;
  localparam int HA  = 12;
  localparam int HS0 = 14;
  localparam int VT  = 10;
  localparam int VA  = 6;
  localparam int VS0 = 7;
  localparam int LL  = 4;

  logic        clk = 1'b0;
  logic        rst, pix_ce, vga_hs, vga_vs;
  logic [11:0] vga_i;
  logic        pix_valid, frame_start, locked, lock_lost;
  logic [9:0]  pix_x, pix_y;
  logic [11:0] pix_data, line_len;

  int n_chk  = 0;
  int n_pass = 0;
  int n_valid = 0;
  int n_fs    = 0;
  int base_valid, base_fs;
  logic force_hi = 1'b0;

  vga_sync_rx #(
    .H_TOTAL(HT), .H_ACTIVE(HA), .H_SYNC_START(HS0),
    .V_TOTAL(VT), .V_ACTIVE(VA), .V_SYNC_START(VS0), .LOCK_LINES(LL)
  ) dut (
    .clk(clk), .rst(rst), .pix_ce(pix_ce), .vga_hs(vga_hs), .vga_vs(vga_vs),
    .vga_i(vga_i), .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
    .pix_data(pix_data), .frame_start(frame_start), .locked(locked),
    .lock_lost(lock_lost), .line_len(line_len)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (pix_valid) n_valid++;
    if (frame_start) n_fs++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // One transmitter sample: pix_ce high for one clock, low for the next.
  task automatic send_sample(input int h, input int v);
    @(negedge clk);
    pix_ce = 1'b1;
    vga_hs = force_hi || !(h >= HS0 && h < HS0 + 2);
    vga_vs = force_hi || !(v >= VS0 && v < VS0 + 2);
    vga_i  = (h == 5) ? 12'hf00 : 12'(v * 32 + h);
    @(negedge clk);
    pix_ce = 1'b0;
  endtask

  task automatic send_range(input int v, input int h0, input int h1);
    for (int h = h0; h <= h1; h++) send_sample(h, v);
  endtask

  task automatic send_lines(input int v0, input int v1);
    for (int v = v0; v <= v1; v++) send_range(v, 0, HT - 1);
  endtask

  task automatic send_frame(input int nlines);
    send_lines(0, nlines - 1);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; pix_ce = 1'b0; vga_hs = 1'b1; vga_vs = 1'b1; vga_i = '0;
    repeat (3) @(negedge clk);
    chk("rst_pix_valid", 32'(pix_valid), 0);
    chk("rst_pix_x", 32'(pix_x), 0);
    chk("rst_pix_data", 32'(pix_data), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_lock_lost", 32'(lock_lost), 0);
    chk("rst_line_len", 32'(line_len), 0);
    chk("rst_frame_start", 32'(frame_start), 0);
    rst = 1'b0;

    // Acquire: V_ALIGN after line 4 of frame 1, lock at vsync of frame 2.
    send_frame(VT);
    chk("acq_not_yet", 32'(locked), 0);
    send_frame(VT);
    chk("acq_locked", 32'(locked), 1);
    chk("acq_line_len", 32'(line_len), HT);

    base_valid = n_valid; base_fs = n_fs;
    send_lines(0, 1);
    send_range(2, 0, 5);
    chk("pix_valid_at_5_2", 32'(pix_valid), 1);
    chk("pix_x_at_5", 32'(pix_x), 5);
    chk("pix_y_at_2", 32'(pix_y), 2);
    chk("pix_data_f00", 32'(pix_data), 32'h0f00);
    send_range(2, 6, HT - 1);
    send_lines(3, VT - 1);
    send_frame(VT);
    chk("steady_valid_count", 32'(n_valid - base_valid), 2 * HA * VA);
    chk("steady_frame_starts", 32'(n_fs - base_fs), 2);

    // One long line while locked.
    send_lines(0, 1);
    send_range(2, 0, HT);
    send_range(3, 0, HS0);
    chk("long_line_unlock", 32'(locked), 0);
    chk("long_line_lost", 32'(lock_lost), 1);
    chk("long_line_len", 32'(line_len), HT + 1);
    send_range(3, HS0 + 1, HT - 1);
    send_lines(4, VT - 1);
    send_frame(VT);
    chk("relock_not_yet", 32'(locked), 0);
    send_frame(VT);
    chk("relock_locked", 32'(locked), 1);

    // Sync stuck high past the timeout.
    force_hi = 1'b1;
    for (int i = 0; i < 1100; i++) send_sample(0, 0);
    force_hi = 1'b0;
    chk("timeout_unlock", 32'(locked), 0);
    chk("timeout_line_len", 32'(line_len), 1024);
    chk("timeout_lost_sticky", 32'(lock_lost), 1);

    // Asynchronous reset in the middle of an active line.
    send_lines(0, 1);
    send_range(2, 0, 5);
    #2 rst = 1'b1;
    #1;
    chk("arst_pix_x", 32'(pix_x), 0);
    chk("arst_pix_data", 32'(pix_data), 0);
    chk("arst_line_len", 32'(line_len), 0);
    chk("arst_lock_lost", 32'(lock_lost), 0);
    @(negedge clk);
    rst = 1'b0;
    send_frame(VT);
    send_frame(VT);
    chk("arst_relock", 32'(locked), 1);
    chk("arst_relock_no_lost", 32'(lock_lost), 0);

    // Short frame during V_ALIGN: realign without lock or lock_lost.
    pulse_reset();
    send_frame(VT - 1);
    send_frame(VT);
    chk("short_frame_no_lock", 32'(locked), 0);
    chk("short_frame_no_lost", 32'(lock_lost), 0);
    send_lines(0, VS0);
    chk("short_frame_then_lock", 32'(locked), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/vga_sync_rx.md
VGA_SYNC_RX -- requirements
Module: vga_sync_rx

Interface
REQ-001 Parameter H_TOTAL, default 800, pixel clocks per line.
REQ-002 Parameter H_ACTIVE, default 640, visible pixels per line.
REQ-003 Parameter H_SYNC_START, default 656, pixel index at which hsync falls.
REQ-004 Parameter V_TOTAL, default 525, lines per frame.
REQ-005 Parameter V_ACTIVE, default 480, visible lines per frame.
REQ-006 Parameter V_SYNC_START, default 490, line index at which vsync falls.
REQ-007 Parameter LOCK_LINES, default 4, consecutive correct lines needed for horizontal alignment.
REQ-008 clk  input  1  single system clock; all logic on its rising edge.
REQ-009 rst  input  1  asynchronous, active-high reset.
REQ-010 pix_ce  input  1  pixel-clock enable; one sample per asserted cycle.
REQ-011 vga_hs  input  1  horizontal sync, active low.
REQ-012 vga_vs  input  1  vertical sync, active low.
REQ-013 vga_i  input  12  RGB444 pixel data.
REQ-014 pix_valid  output  1  registered; captured pixel is inside the active area while locked.
REQ-015 pix_x  output  10  registered column of the captured pixel.
REQ-016 pix_y  output  10  registered row of the captured pixel.
REQ-017 pix_data  output  12  registered captured vga_i.
REQ-018 frame_start  output  1  one-clk pulse when pixel (0,0) is output while locked.
REQ-019 locked  output  1  high in LOCKED state.
REQ-020 lock_lost  output  1  sticky; set on LOCKED->SEARCH; cleared only by rst.
REQ-021 line_len  output  12  last measured hsync-fall-to-hsync-fall period, in pix_ce samples.

Function
REQ-022 All sampling, counting and edge detection SHALL advance only on cycles with pix_ce=1.
REQ-023 The hsync fall SHALL be detected as previous sample 1 and current sample 0; the vsync fall SHALL be detected the same way.
REQ-024 Internal hcnt SHALL count 0..H_TOTAL-1 and wrap to 0; vcnt SHALL increment on each hcnt wrap and wrap to 0 after V_TOTAL-1.
REQ-025 On an hsync fall, hcnt SHALL load H_SYNC_START; a period counter SHALL latch into line_len and restart at 1.
REQ-026 The period counter SHALL saturate at 4095; when it reaches 1024 with no hsync fall, the state SHALL go to SEARCH.
REQ-027 States: SEARCH, H_ALIGN, V_ALIGN, LOCKED; reset state is SEARCH.
REQ-028 SEARCH: on the first hsync fall, go to H_ALIGN and clear the good-line count.
REQ-029 H_ALIGN: on each hsync fall, increment the good-line count if the period equals H_TOTAL, else clear it; at LOCK_LINES, go to V_ALIGN.
REQ-030 V_ALIGN: on a vsync fall, load vcnt with V_SYNC_START and clear the line counter; on the next vsync fall, go to LOCKED if the line count equals V_TOTAL, else re-align and stay.
REQ-031 LOCKED: go to SEARCH and set lock_lost on any hsync period other than H_TOTAL, any frame length other than V_TOTAL, or the timeout.
REQ-032 In H_ALIGN and V_ALIGN, a wrong hsync period SHALL return the state to SEARCH; lock_lost SHALL NOT be set.
REQ-033 Simultaneous hsync and vsync falls SHALL both apply in the same cycle: hcnt load and vcnt load.
REQ-034 Latency: outputs SHALL update on the clk edge after the pix_ce sample and hold between samples.
REQ-035 pix_valid SHALL be 1 only for LOCKED, pix_ce, hcnt<H_ACTIVE and vcnt<V_ACTIVE.
REQ-036 pix_x/pix_y SHALL equal hcnt/vcnt of that sample; pix_data SHALL equal vga_i.

Reset
REQ-037 On rst, the outputs SHALL be 0: pix_valid, pix_x, pix_y, pix_data, frame_start, locked, lock_lost, line_len.
REQ-038 On rst, the counters SHALL be 0 and the previous-sync registers SHALL be 1; reset applied mid-frame SHALL re-enter SEARCH.

Structure
REQ-039 The timing defaults SHALL reside in a shared package vga_timing_pkg, along with the state encoding; the transmitter and this receiver SHALL both use it.
REQ-040 Sub-module vga_edge_det SHALL provide the registered falling-edge detection, qualified by pix_ce, one instance per sync.

Verification
REQ-041 Scenario: pix_ce=1 on alternate cycles, 640x480 transmitter model, two frames -> locked by the end of frame 2; pixel at hcnt 300 gives pix_x=300, pix_data=12'hf00.
REQ-042 Scenario: one line lengthened to 801 while locked -> next cycle locked=0 and lock_lost=1; lock returns after LOCK_LINES lines plus one full frame.
REQ-043 Scenario: sync held high for 1100 samples -> SEARCH, locked=0, line_len=1024.
REQ-044 Scenario: frame of 524 lines in V_ALIGN -> no lock, no lock_lost; next 525-line frame -> locked.
REQ-045 Scenario: rst pulsed mid-active-line -> all outputs 0 asynchronously; relock follows the timing of REQ-041.
REQ-046 Scenario: locked steady state -> exactly 307200 pix_valid and one frame_start per frame.
